oc3to7_serializer: RTL and testbench

- Transmit-side complement of the 7-input ones counter: takes a 3-bit ones count and regenerates a 7-slot serial frame containing exactly that many ones, thermometer-ordered (ones first).
- Also presents the frame as a registered 7-bit parallel thermometer word.
- Sits upstream of the ones counter, so the counter's 3-bit result equals the count sent here.
- Uses a start/ready handshake, a frame strobe and a done pulse.

---
 rtl/oc3to7_serializer.sv | 145 ++++++++++++++
 tb/tb_oc3to7_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/oc3to7_serializer.sv
// Serializes a ones count into a thermometer-ordered frame of SLOTS slots, with a parallel thermometer copy.
// Optional macro LOOPBACK_CHECK_EN adds a ones counter that flags frames whose sent ones differ from the count.
module oc3to7_serializer #(
    parameter int SLOTS = 7,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    count,
    output logic             ready,
    output logic             sout,
    output logic             sframe,
    output logic             done,
    output logic [SLOTS-1:0] therm,
    output logic             err
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);
    localparam logic [CW-1:0] LAST_C  = CW'(SLOTS - 1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    k_reg, k_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [SLOTS-1:0] therm_reg, therm_next;
    logic             sout_reg, sout_next;
    logic             sframe_reg, sframe_next;
    logic             done_reg, done_next;
    logic             ready_reg, ready_next;

    logic [CW-1:0]    count_clamped;
    logic [CW-1:0]    k_inc;
    logic [SLOTS-1:0] therm_load;

    assign count_clamped = (count > SLOTS_C) ? SLOTS_C : count;
    assign k_inc         = k_reg + ONE_C;

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_therm
            assign therm_load[gi] = (CW'(gi) < count_clamped);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            k_reg      <= '0;
            cnt_reg    <= '0;
            therm_reg  <= '0;
            sout_reg   <= 1'b0;
            sframe_reg <= 1'b0;
            done_reg   <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            cnt_reg    <= cnt_next;
            therm_reg  <= therm_next;
            sout_reg   <= sout_next;
            sframe_reg <= sframe_next;
            done_reg   <= done_next;
            ready_reg  <= ready_next;
        end
    end

    // Outputs are computed one cycle ahead so each *_reg shows the slot of the current state.
    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        cnt_next    = cnt_reg;
        therm_next  = therm_reg;
        sout_next   = 1'b0;
        sframe_next = 1'b0;
        done_next   = 1'b0;
        ready_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cnt_next    = count_clamped;
                    therm_next  = therm_load;
                    k_next      = '0;
                    sout_next   = |count_clamped;
                    sframe_next = 1'b1;
                    state_next  = ST_SHIFT;
                end else begin
                    ready_next = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (k_reg == LAST_C) begin
                    done_next  = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    k_next      = k_inc;
                    sout_next   = (k_inc < cnt_reg);
                    sframe_next = 1'b1;
                end
            end
            ST_DONE: begin
                ready_next = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                ready_next = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ready  = ready_reg;
    assign sout   = sout_reg;
    assign sframe = sframe_reg;
    assign done   = done_reg;
    assign therm  = therm_reg;

`ifdef LOOPBACK_CHECK_EN
    logic [CW-1:0] ones_reg;
    logic          err_reg;

    // Counts ones actually driven on sout; compared against the latched count while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                ones_reg <= '0;
            end else if (state_reg == ST_SHIFT && sout_reg) begin
                ones_reg <= ones_reg + ONE_C;
            end
            if (state_reg == ST_DONE && ones_reg != cnt_reg) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_oc3to7_serializer.sv
// Directed bench for oc3to7_serializer: default 7-slot instance plus a 5-slot instance for clamping.
module tb_oc3to7_serializer;
    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] count;
    logic       ready, sout, sframe, done, err;
    logic [6:0] therm;

    logic       start5;
    logic [2:0] count5;
    logic       ready5, sout5, sframe5, done5, err5;
    logic [4:0] therm5;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t_acc1, t_acc2;

    oc3to7_serializer #(.SLOTS(7), .CW(3)) dut (
        .clk(clk), .rst(rst), .start(start), .count(count), .ready(ready),
        .sout(sout), .sframe(sframe), .done(done), .therm(therm), .err(err)
    );

    oc3to7_serializer #(.SLOTS(5), .CW(3)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .count(count5), .ready(ready5),
        .sout(sout5), .sframe(sframe5), .done(done5), .therm(therm5), .err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle right after acceptance; returns in the first IDLE cycle.
    task automatic run_frame(input string name, input logic [6:0] pat, input logic [6:0] th,
                             input bit toggle);
        for (int s = 0; s < 7; s++) begin
            chk($sformatf("%s slot%0d sout", name, s), sout, pat[s]);
            chk($sformatf("%s slot%0d sframe", name, s), sframe, 1'b1);
            chk($sformatf("%s slot%0d ready", name, s), ready, 1'b0);
            chk($sformatf("%s slot%0d done", name, s), done, 1'b0);
            chk($sformatf("%s slot%0d therm", name, s), therm, th);
            if (toggle) count = (count == 3'd5) ? 3'd1 : 3'd5;
            tick();
        end
        chk({name, " done pulse"}, done, 1'b1);
        chk({name, " done sframe"}, sframe, 1'b0);
        chk({name, " done sout"}, sout, 1'b0);
        chk({name, " done ready"}, ready, 1'b0);
        chk({name, " done therm"}, therm, th);
        tick();
        chk({name, " idle ready"}, ready, 1'b1);
        chk({name, " idle done"}, done, 1'b0);
        chk({name, " idle sframe"}, sframe, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = 3'd0; start5 = 1'b0; count5 = 3'd0;
        tick();
        tick();
        chk("reset ready", ready, 1'b1);
        chk("reset sout", sout, 1'b0);
        chk("reset sframe", sframe, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset therm", therm, 7'b0000000);
        chk("reset err", err, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle ready", ready, 1'b1);
        chk("idle sframe", sframe, 1'b0);

        // count=3 single frame
        start = 1'b1; count = 3'd3;
        tick();
        start = 1'b0;
        run_frame("c3", 7'b0000111, 7'b0000111, 1'b0);

        // back-to-back count=0 then count=7 with start held high
        start = 1'b1; count = 3'd0;
        tick();
        t_acc1 = cyc;
        run_frame("c0", 7'b0000000, 7'b0000000, 1'b0);
        count = 3'd7;
        tick();
        t_acc2 = cyc;
        chk("b2b spacing", t_acc2 - t_acc1, 9);
        run_frame("c7", 7'b1111111, 7'b1111111, 1'b0);
        start = 1'b0;
        tick();
        chk("after b2b sframe", sframe, 1'b0);
        chk("after b2b ready", ready, 1'b1);

        // start held, count toggling: only the sampled 5 is sent
        start = 1'b1; count = 3'd5;
        tick();
        run_frame("c5tog", 7'b0011111, 7'b0011111, 1'b1);
        start = 1'b0;
        tick();
        chk("after tog sframe", sframe, 1'b0);

        // reset in slot 3 of a count=6 frame
        start = 1'b1; count = 3'd6;
        tick();
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("c6 slot%0d sout", s), sout, 1'b1);
            tick();
        end
        chk("c6 slot3 sframe", sframe, 1'b1);
        chk("c6 slot3 therm", therm, 7'b0111111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort ready", ready, 1'b1);
        chk("abort sout", sout, 1'b0);
        chk("abort sframe", sframe, 1'b0);
        chk("abort therm", therm, 7'b0000000);
        chk("abort done", done, 1'b0);
        tick();
        chk("abort next done", done, 1'b0);
        chk("abort next sframe", sframe, 1'b0);

        // 5-slot instance: count=7 clamps to 5
        start5 = 1'b1; count5 = 3'd7;
        tick();
        start5 = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("s5 slot%0d sout", s), sout5, 1'b1);
            chk($sformatf("s5 slot%0d sframe", s), sframe5, 1'b1);
            chk($sformatf("s5 slot%0d therm", s), therm5, 5'b11111);
            tick();
        end
        chk("s5 done pulse", done5, 1'b1);
        chk("s5 done sframe", sframe5, 1'b0);
        tick();
        chk("s5 idle ready", ready5, 1'b1);
        chk("s5 idle done", done5, 1'b0);

        chk("final err", err, 1'b0);
        chk("final err5", err5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
